// File: rtl/wb_check_pkg.sv
// wb_check_pkg: shared types and helpers for the writeback trace checker.
package wb_check_pkg;

   localparam int unsigned CYC_W = 16;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPass,
      StFail
   } state_e;

   // Index width for a RAM of the given depth (at least one bit).
   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/wb_exp_ram.sv
// wb_exp_ram: expected-value store, one synchronous write port, one asynchronous read port.
// No reset: contents survive a checker reset so a run can be repeated.
module wb_exp_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned AW     = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; a same-cycle read of the written address still sees the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_checker.sv
// wb_trace_checker: compares the core writeback stream beat-by-beat against a preloaded
// expected sequence and registers a pass/fail verdict, first-failure info and a cycle count.
// Optional build macro WB_CHECK_SKIP_ZERO_EN: zero-valued writebacks are not counted as beats.
module wb_trace_checker
   import wb_check_pkg::*;
#(
   parameter int unsigned  DATA_W  = 32,
   parameter int unsigned  DEPTH   = 16,
   parameter int unsigned  TIMEOUT = 64,
   localparam int unsigned IW      = idx_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exp_we,
   input  logic [IW-1:0]     exp_addr,
   input  logic [DATA_W-1:0] exp_wdata,
   input  logic [IW:0]       exp_count,
   input  logic              start,
   input  logic              wb_valid,
   input  logic [DATA_W-1:0] wb_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [IW-1:0]     mismatch_idx,
   output logic [DATA_W-1:0] mismatch_data,
   output logic [CYC_W-1:0]  cycle_count
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   state_e            state_q;
   logic [IW:0]       count_q;
   logic [IW-1:0]     idx_q;
   logic [TW-1:0]     idle_q;
   logic [DATA_W-1:0] exp_rdata;
   logic [IW:0]       count_clamped;
   logic              accept;
   logic              last_beat;

   wb_exp_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (IW)
   ) u_ram (
      .clk   (clk),
      .we    (exp_we),
      .waddr (exp_addr),
      .wdata (exp_wdata),
      .raddr (idx_q),
      .rdata (exp_rdata)
   );

   // Beat qualification, run-length clamp and last-beat detection.
   always_comb begin
`ifdef WB_CHECK_SKIP_ZERO_EN
      accept = wb_valid && (wb_data != '0);
`else
      accept = wb_valid;
`endif
      count_clamped = (exp_count > (IW+1)'(DEPTH)) ? (IW+1)'(DEPTH) : exp_count;
      last_beat     = ({1'b0, idx_q} == (count_q - (IW+1)'(1)));
   end

   // Checker FSM with registered verdict, capture and counter outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         count_q       <= '0;
         idx_q         <= '0;
         idle_q        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         fail          <= 1'b0;
         timeout       <= 1'b0;
         mismatch_idx  <= '0;
         mismatch_data <= '0;
         cycle_count   <= '0;
      end else if (start) begin
         // Start from any state, including an abort of a run in progress.
         count_q       <= count_clamped;
         idx_q         <= '0;
         idle_q        <= '0;
         timeout       <= 1'b0;
         fail          <= 1'b0;
         mismatch_idx  <= '0;
         mismatch_data <= '0;
         cycle_count   <= CYC_W'(1);
         if (count_clamped == '0) begin
            state_q <= StPass;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b1;
         end else begin
            state_q <= StRun;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
         end
      end else begin
         case (state_q)
            StRun: begin
               if (cycle_count != '1) begin
                  cycle_count <= cycle_count + CYC_W'(1);
               end
               if (accept) begin
                  if (wb_data == exp_rdata) begin
                     idle_q <= '0;
                     if (last_beat) begin
                        state_q <= StPass;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b1;
                     end else begin
                        idx_q <= idx_q + IW'(1);
                     end
                  end else begin
                     state_q       <= StFail;
                     busy          <= 1'b0;
                     done          <= 1'b1;
                     fail          <= 1'b1;
                     mismatch_idx  <= idx_q;
                     mismatch_data <= wb_data;
                  end
               end else if (idle_q == TW'(TIMEOUT - 1)) begin
                  state_q       <= StFail;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  fail          <= 1'b1;
                  timeout       <= 1'b1;
                  mismatch_idx  <= idx_q;
                  mismatch_data <= '0;
               end else begin
                  idle_q <= idle_q + TW'(1);
               end
            end
            default: begin
               // Idle, pass and fail hold until the next start.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker: table-driven directed runs plus hand-written multi-cycle sequences.
module tb_wb_trace_checker;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned DEPTH   = 16;
   localparam int unsigned TIMEOUT = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              exp_we = 1'b0;
   logic [3:0]        exp_addr = '0;
   logic [31:0]       exp_wdata = '0;
   logic [4:0]        exp_count = '0;
   logic              start = 1'b0;
   logic              wb_valid = 1'b0;
   logic [31:0]       wb_data = '0;
   logic              busy, done, pass, fail, timeout;
   logic [3:0]        mismatch_idx;
   logic [31:0]       mismatch_data;
   logic [15:0]       cycle_count;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_trace_checker #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .exp_we        (exp_we),
      .exp_addr      (exp_addr),
      .exp_wdata     (exp_wdata),
      .exp_count     (exp_count),
      .start         (start),
      .wb_valid      (wb_valid),
      .wb_data       (wb_data),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .fail          (fail),
      .timeout       (timeout),
      .mismatch_idx  (mismatch_idx),
      .mismatch_data (mismatch_data),
      .cycle_count   (cycle_count)
   );

   // exp/beat arrays are packed: element 0 is the rightmost item of each concatenation.
   typedef struct {
      int              n_exp;
      logic [3:0][31:0] exp;
      logic [4:0]      count;
      int              n_beat;
      logic [5:0][31:0] beat;
      logic [5:0]      vld;
      logic            e_pass;
      logic            e_fail;
      logic            e_to;
      logic [3:0]      e_idx;
      logic [31:0]     e_data;
      logic [15:0]     e_cyc;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int k, input vec_t v);
      int waited;
      for (int i = 0; i < v.n_exp; i++) begin
         @(negedge clk);
         exp_we    = 1'b1;
         exp_addr  = 4'(i);
         exp_wdata = v.exp[i];
      end
      @(negedge clk);
      exp_we    = 1'b0;
      start     = 1'b1;
      exp_count = v.count;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("v%0d.busy_after_start", k), 32'(busy), 32'(v.count != 0));
      chk($sformatf("v%0d.done_after_start", k), 32'(done), 32'(v.count == 0));
      for (int i = 0; i < v.n_beat; i++) begin
         wb_valid = v.vld[i];
         wb_data  = v.beat[i];
         @(negedge clk);
      end
      wb_valid = 1'b0;
      wb_data  = '0;
      waited   = 0;
      while (!done && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      chk($sformatf("v%0d.done", k), 32'(done), 32'd1);
      chk($sformatf("v%0d.busy", k), 32'(busy), 32'd0);
      chk($sformatf("v%0d.pass", k), 32'(pass), 32'(v.e_pass));
      chk($sformatf("v%0d.fail", k), 32'(fail), 32'(v.e_fail));
      chk($sformatf("v%0d.timeout", k), 32'(timeout), 32'(v.e_to));
      chk($sformatf("v%0d.mismatch_idx", k), 32'(mismatch_idx), 32'(v.e_idx));
      chk($sformatf("v%0d.mismatch_data", k), mismatch_data, v.e_data);
      chk($sformatf("v%0d.cycle_count", k), 32'(cycle_count), 32'(v.e_cyc));
   endtask

   initial begin
      vec_t rv;

      // Back-to-back correct beats.
      vecs[0] = '{n_exp: 3, exp: {32'd0, 32'd12, 32'd7, 32'd5}, count: 5'd3,
                  n_beat: 3, beat: {32'd0, 32'd0, 32'd0, 32'd12, 32'd7, 32'd5}, vld: 6'b000111,
                  e_pass: 1, e_fail: 0, e_to: 0, e_idx: 0, e_data: 0, e_cyc: 16'd4};
      // Mismatch on the middle beat.
      vecs[1] = '{n_exp: 3, exp: {32'd0, 32'd12, 32'd7, 32'd5}, count: 5'd3,
                  n_beat: 3, beat: {32'd0, 32'd0, 32'd0, 32'd12, 32'd9, 32'd5}, vld: 6'b000111,
                  e_pass: 0, e_fail: 1, e_to: 0, e_idx: 1, e_data: 32'd9, e_cyc: 16'd3};
      // No beats at all: timeout after TIMEOUT idle cycles.
      vecs[2] = '{n_exp: 1, exp: {32'd0, 32'd0, 32'd0, 32'd5}, count: 5'd1,
                  n_beat: 0, beat: '0, vld: 6'b000000,
                  e_pass: 0, e_fail: 1, e_to: 1, e_idx: 0, e_data: 0, e_cyc: 16'd65};
`ifdef WB_CHECK_SKIP_ZERO_EN
      vecs[3] = '{n_exp: 2, exp: {32'd0, 32'd0, 32'd4, 32'd3}, count: 5'd2,
                  n_beat: 5, beat: {32'd0, 32'd4, 32'd0, 32'd0, 32'd3, 32'd0}, vld: 6'b011111,
                  e_pass: 1, e_fail: 0, e_to: 0, e_idx: 0, e_data: 0, e_cyc: 16'd6};
`else
      vecs[3] = '{n_exp: 2, exp: {32'd0, 32'd0, 32'd4, 32'd3}, count: 5'd2,
                  n_beat: 5, beat: {32'd0, 32'd4, 32'd0, 32'd0, 32'd3, 32'd0}, vld: 6'b011111,
                  e_pass: 0, e_fail: 1, e_to: 0, e_idx: 0, e_data: 0, e_cyc: 16'd2};
`endif
      // Zero-length run passes immediately.
      vecs[4] = '{n_exp: 0, exp: '0, count: 5'd0,
                  n_beat: 0, beat: '0, vld: 6'b000000,
                  e_pass: 1, e_fail: 0, e_to: 0, e_idx: 0, e_data: 0, e_cyc: 16'd1};
      // Gaps between beats.
      vecs[5] = '{n_exp: 3, exp: {32'd0, 32'd3, 32'd2, 32'd1}, count: 5'd3,
                  n_beat: 5, beat: {32'd0, 32'd3, 32'd77, 32'd2, 32'd66, 32'd1},
                  vld: 6'b010101,
                  e_pass: 1, e_fail: 0, e_to: 0, e_idx: 0, e_data: 0, e_cyc: 16'd6};
      // Mismatch on the last beat.
      vecs[6] = '{n_exp: 3, exp: {32'd0, 32'd12, 32'd7, 32'd5}, count: 5'd3,
                  n_beat: 3, beat: {32'd0, 32'd0, 32'd0, 32'd13, 32'd7, 32'd5}, vld: 6'b000111,
                  e_pass: 0, e_fail: 1, e_to: 0, e_idx: 2, e_data: 32'd13, e_cyc: 16'd4};
      // Invalid cycle carrying wrong data is not a beat.
      vecs[7] = '{n_exp: 1, exp: {32'd0, 32'd0, 32'd0, 32'd9}, count: 5'd1,
                  n_beat: 2, beat: {32'd0, 32'd0, 32'd0, 32'd0, 32'd9, 32'd1}, vld: 6'b000010,
                  e_pass: 1, e_fail: 0, e_to: 0, e_idx: 0, e_data: 0, e_cyc: 16'd3};
      // Failing beat with a large value.
      vecs[8] = '{n_exp: 2, exp: {32'd0, 32'd0, 32'hDEAD_BEEF, 32'h1234_5678}, count: 5'd2,
                  n_beat: 2, beat: {32'd0, 32'd0, 32'd0, 32'd0, 32'hDEAD_BEEE, 32'h1234_5678},
                  vld: 6'b000011,
                  e_pass: 0, e_fail: 1, e_to: 0, e_idx: 1, e_data: 32'hDEAD_BEEE, e_cyc: 16'd3};

      // Reset state.
      #1;
      chk("reset.flags", 32'({busy, done, pass, fail, timeout}), 32'd0);
      chk("reset.mismatch_idx", 32'(mismatch_idx), 32'd0);
      chk("reset.mismatch_data", mismatch_data, 32'd0);
      chk("reset.cycle_count", 32'(cycle_count), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < 9; k++) begin
         run_vec(k, vecs[k]);
      end

      // exp_count above DEPTH is clamped: 16 correct beats must pass.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         exp_we    = 1'b1;
         exp_addr  = 4'(i);
         exp_wdata = 32'(i * 3 + 1);
      end
      @(negedge clk);
      exp_we    = 1'b0;
      start     = 1'b1;
      exp_count = 5'd20;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         wb_valid = 1'b1;
         wb_data  = 32'(i * 3 + 1);
         @(negedge clk);
      end
      wb_valid = 1'b0;
      chk("clamp.pass", 32'(pass), 32'd1);
      chk("clamp.done", 32'(done), 32'd1);
      chk("clamp.cycle_count", 32'(cycle_count), 32'd17);

      // Same-cycle write to the compared address uses the old word; then restart mid-run.
      @(negedge clk);
      exp_we = 1'b1; exp_addr = 4'd0; exp_wdata = 32'd5;
      @(negedge clk);
      exp_addr = 4'd1; exp_wdata = 32'd7;
      @(negedge clk);
      exp_we = 1'b0; start = 1'b1; exp_count = 5'd2;
      @(negedge clk);
      start = 1'b0;
      wb_valid = 1'b1; wb_data = 32'd5;
      exp_we = 1'b1; exp_addr = 4'd0; exp_wdata = 32'd99;
      @(negedge clk);
      exp_we = 1'b0;
      chk("wr_old.busy", 32'(busy), 32'd1);
      chk("wr_old.fail", 32'(fail), 32'd0);
      start = 1'b1; exp_count = 5'd2; wb_data = 32'd123;
      @(negedge clk);
      start = 1'b0; wb_data = 32'd99;
      @(negedge clk);
      wb_data = 32'd7;
      @(negedge clk);
      wb_valid = 1'b0;
      chk("restart.pass", 32'(pass), 32'd1);
      chk("restart.cycle_count", 32'(cycle_count), 32'd3);

      // Reset two beats into a three-beat run, then rerun on the retained RAM.
      @(negedge clk);
      exp_we = 1'b1; exp_addr = 4'd0; exp_wdata = 32'd5;
      @(negedge clk);
      exp_addr = 4'd1; exp_wdata = 32'd7;
      @(negedge clk);
      exp_addr = 4'd2; exp_wdata = 32'd12;
      @(negedge clk);
      exp_we = 1'b0; start = 1'b1; exp_count = 5'd3;
      @(negedge clk);
      start = 1'b0; wb_valid = 1'b1; wb_data = 32'd5;
      @(negedge clk);
      wb_data = 32'd7;
      @(negedge clk);
      wb_valid = 1'b0;
      chk("midrst.busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst.flags", 32'({busy, done, pass, fail, timeout}), 32'd0);
      chk("midrst.cycle_count", 32'(cycle_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rv = vecs[0];
      rv.n_exp = 0;
      run_vec(9, rv);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Synthesizable self-check block that consumes the pipelined MIPS core's writeback stream (`writedata` plus a valid strobe) and compares it beat-by-beat against an expected sequence preloaded into a small local RAM. It sits beside the core in the simulation top and in FPGA bring-up builds. It replaces eyeballing a cycle-by-cycle `writedata` print with a registered pass/fail verdict, a mismatch index and a cycle count.

## Interface
- `DATA_W`, 32, writeback data width
- `DEPTH`, 16, max expected beats (power of two)
- `TIMEOUT`, 64, max idle cycles between accepted beats while running
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `exp_we`  in  1  write strobe for expected-value RAM
- `exp_addr`  in  log2(DEPTH)  expected-value RAM write address
- `exp_wdata`  in  DATA_W  expected value
- `exp_count`  in  log2(DEPTH)+1  number of beats to check, sampled on `start`
- `start`  in  1  one-cycle pulse; begins a check run
- `wb_valid`  in  1  writeback beat present this cycle
- `wb_data`  in  DATA_W  core `writedata`
- `busy`  out  1  run in progress
- `done`  out  1  verdict available (sticky until next `start`)
- `pass`  out  1  all beats matched
- `fail`  out  1  mismatch or timeout
- `timeout`  out  1  fail caused by timeout
- `mismatch_idx`  out  log2(DEPTH)  index of first failing beat
- `mismatch_data`  out  DATA_W  observed value at first failure
- `cycle_count`  out  16  cycles from `start` to verdict, saturating

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE: `start`=1 latches `exp_count`, clears `idx`, idle counter, `cycle_count`, verdict outputs; -> RUN. If `exp_count`=0 -> PASS directly.
- RUN: an accepted beat (see Configuration) compares `wb_data` with RAM[`idx`]. Equal: `idx`++, idle counter cleared; on last beat (`idx`=count-1) -> PASS. Not equal: capture `idx`, `wb_data` -> FAIL.
- RUN: no accepted beat: idle counter++; reaching `TIMEOUT` -> FAIL with `timeout`=1, `mismatch_idx`=`idx`, `mismatch_data`=0.
- PASS/FAIL: hold outputs; ignore `wb_valid`; `start` re-arms as from IDLE.
- `start` during RUN: restarts the run (abort current, same as IDLE start).
- `exp_count` > DEPTH: clamp to DEPTH.
- `exp_we` is accepted in any state; a write to the address being compared in the same cycle uses the old value.
- `cycle_count` saturates at 16'hFFFF.

## Timing
- Reset: state IDLE; `busy`, `done`, `pass`, `fail`, `timeout`=0; `mismatch_idx`, `mismatch_data`, `cycle_count`=0.
- RAM read is combinational on `idx`. Compare and verdict register on the same edge that samples the beat. `done`/`pass`/`fail` are high the cycle after the deciding beat.
- `busy`=1 from the cycle after `start` until the cycle the verdict appears; `busy` and `done` are never both 1.
- `rst` mid-run aborts immediately to reset values; RAM contents are unaffected (no reset on RAM).

## Configuration
- `WB_CHECK_SKIP_ZERO_EN` defined: a beat is accepted only when `wb_valid`=1 and `wb_data`!=0. This treats zero writebacks from pipeline bubbles and nops as non-beats; they still count toward idle/timeout.
- Undefined: every `wb_valid`=1 cycle is a beat, including zero data.

## Structure
- `wb_check_pkg`: state enum (IDLE/RUN/PASS/FAIL), `CYC_W`=16, the helper function computing the index width.
- Sub-module `wb_exp_ram`: DEPTH×DATA_W, one synchronous write port and one asynchronous read port. The top holds the FSM, counters and capture registers.

## Test plan
- Load [5,7,12], `exp_count`=3, `start`, drive beats 5,7,12 back-to-back -> `pass`=1, `done`=1 one cycle after beat 12, `cycle_count`=4.
- Same load, drive 5,9,12 -> `fail`=1 after beat 9, `mismatch_idx`=1, `mismatch_data`=9, `timeout`=0.
- Load [5], drive no beats, TIMEOUT=64 -> `fail`=1, `timeout`=1 at cycle 64 after start, `mismatch_idx`=0.
- With `WB_CHECK_SKIP_ZERO_EN`: expected [3,4], stream 0,3,0,0,4 all valid -> `pass`=1. Without the macro, the same stream gives `fail` with `mismatch_idx`=0, `mismatch_data`=0.
- `exp_count`=0, `start` -> `pass`=1 next cycle, `busy` never asserted.
- Assert `rst` two beats into a 3-beat run -> all outputs 0 the same cycle. A new `start` with the stored RAM plus a correct stream -> `pass`=1.
